// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: receive-side packet assembler for the orbital telemetry reply.
// Deserialises a fixed-length 8N1 packet, writes each byte to the frame
// buffer, and reports framing, timeout and sequence status at window close.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | window closed, waiting for rxOpen
// S_WAIT  | window open, waiting for a start edge (timeout running)
// S_START | start bit seen, counting to mid-bit to qualify it
// S_DATA  | sampling 8 data bits, LSB first
// S_STOP  | sampling the stop bit, writing the byte if it is valid
// S_DONE  | one cycle to publish pktDone and the status flags
module uart_pkt_rx #(
    parameter int BIT_CLKS     = 34,
    parameter int PKT_LEN      = 20,
    parameter int TIMEOUT_CLKS = 4096,
    parameter int SEQ_STEP     = 8
) (
    input  logic       clk80MHz,
    input  logic       rst,
    input  logic       rxOpen,
    input  logic       UART_RX,
    output logic       UART_dRX,
    output logic       wrEn,
    output logic [4:0] wrAddr,
    output logic [7:0] wrData,
    output logic       pktDone,
    output logic       pktOk,
    output logic       errFrame,
    output logic       errTimeout,
    output logic       errSeq,
    output logic       busy
);

    localparam int BC_W = $clog2(BIT_CLKS);
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    // Bit timer counts down; the start bit is qualified half a bit in,
    // every later sample lands one full bit after the previous one.
    localparam logic [BC_W-1:0] BIT_HALF = BC_W'(BIT_CLKS / 2);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(BIT_CLKS - 1);
    localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [4:0]      IDX_LAST = 5'(PKT_LEN - 1);
    localparam logic [7:0]      STEP     = 8'(SEQ_STEP);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_STOP, S_DONE
    } state_t;

    // Why the window is closing; decoded into the status flags in S_DONE.
    typedef enum logic [1:0] {
        R_COMPLETE, R_FRAME, R_TIMEOUT
    } reason_t;

    state_t          state_q, state_d;
    reason_t         reason_q, reason_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic            rx_prev_q, rx_prev_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      data_cnt_q, data_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [4:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      byte0_q, byte0_d;
    logic [7:0]      last_seq_q, last_seq_d;
    logic            seq_valid_q, seq_valid_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            pkt_done_q, pkt_done_d;
    logic            pkt_ok_q, pkt_ok_d;
    logic            err_frame_q, err_frame_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_seq_q, err_seq_d;
    logic            busy_q, busy_d;
    logic            rx_fall;
    logic            seq_bad;

    // Register bank: synchroniser, FSM, counters, sequence history, outputs.
    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            reason_q      <= R_COMPLETE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            bit_cnt_q     <= '0;
            data_cnt_q    <= '0;
            to_cnt_q      <= '0;
            shift_q       <= '0;
            byte_idx_q    <= '0;
            byte0_q       <= '0;
            last_seq_q    <= '0;
            seq_valid_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            pkt_done_q    <= 1'b0;
            pkt_ok_q      <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_seq_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            reason_q      <= reason_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            data_cnt_q    <= data_cnt_d;
            to_cnt_q      <= to_cnt_d;
            shift_q       <= shift_d;
            byte_idx_q    <= byte_idx_d;
            byte0_q       <= byte0_d;
            last_seq_q    <= last_seq_d;
            seq_valid_q   <= seq_valid_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            pkt_done_q    <= pkt_done_d;
            pkt_ok_q      <= pkt_ok_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            err_seq_q     <= err_seq_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d       = state_q;
        reason_d      = reason_q;
        rx_meta_d     = UART_RX;
        rx_s_d        = rx_meta_q;
        rx_prev_d     = rx_s_q;
        bit_cnt_d     = bit_cnt_q;
        data_cnt_d    = data_cnt_q;
        to_cnt_d      = to_cnt_q;
        shift_d       = shift_q;
        byte_idx_d    = byte_idx_q;
        byte0_d       = byte0_q;
        last_seq_d    = last_seq_q;
        seq_valid_d   = seq_valid_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        pkt_done_d    = 1'b0;
        pkt_ok_d      = pkt_ok_q;
        err_frame_d   = err_frame_q;
        err_timeout_d = err_timeout_q;
        err_seq_d     = err_seq_q;

        rx_fall = rx_prev_q & ~rx_s_q;
        seq_bad = seq_valid_q && (byte0_q != 8'(last_seq_q + STEP));

        unique case (state_q)
            S_IDLE: begin
                if (rxOpen) begin
                    state_d    = S_WAIT;
                    byte_idx_d = '0;
                    to_cnt_d   = TO_LOAD;
                end
            end
            S_WAIT: begin
                if (to_cnt_q == '0) begin
                    state_d  = S_DONE;
                    reason_d = R_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                    if (rx_fall) begin
                        state_d   = S_START;
                        bit_cnt_d = BIT_HALF;
                    end
                end
            end
            S_START: begin
                // A rejected start bit returns to S_WAIT with the idle time
                // it consumed still charged against the timeout.
                if (to_cnt_q != '0) begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
                if (bit_cnt_q == '0) begin
                    if (rx_s_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_DATA;
                        bit_cnt_d  = BIT_LAST;
                        data_cnt_d = 3'd7;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == '0) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = BIT_LAST;
                    if (data_cnt_q == '0) begin
                        state_d = S_STOP;
                    end else begin
                        data_cnt_d = data_cnt_q - 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d  = S_DONE;
                        reason_d = R_FRAME;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = byte_idx_q;
                        wr_data_d  = shift_q;
                        byte_idx_d = byte_idx_q + 5'd1;
                        to_cnt_d   = TO_LOAD;
                        if (byte_idx_q == '0) begin
                            byte0_d = shift_q;
                        end
                        if (byte_idx_q == IDX_LAST) begin
                            state_d  = S_DONE;
                            reason_d = R_COMPLETE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                pkt_done_d    = 1'b1;
                err_frame_d   = (reason_q == R_FRAME);
                err_timeout_d = (reason_q == R_TIMEOUT);
                err_seq_d     = (reason_q == R_COMPLETE) && seq_bad;
                pkt_ok_d      = (reason_q == R_COMPLETE) && !seq_bad;
                // Only a fully received packet advances the sequence history,
                // even when it failed the check, so the next one resyncs.
                if (reason_q == R_COMPLETE) begin
                    last_seq_d  = byte0_q;
                    seq_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Window stays open through the pktDone cycle so it drops one cycle later.
        busy_d = (state_d != S_IDLE) | pkt_done_d;
    end

    assign UART_dRX   = busy_q;
    assign busy       = busy_q;
    assign wrEn       = wr_en_q;
    assign wrAddr     = wr_addr_q;
    assign wrData     = wr_data_q;
    assign pktDone    = pkt_done_q;
    assign pktOk      = pkt_ok_q;
    assign errFrame   = err_frame_q;
    assign errTimeout = err_timeout_q;
    assign errSeq     = err_seq_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: normal packet, sequence tracking, framing
// error, timeouts, start-bit glitch and asynchronous reset mid-packet.
`timescale 1ns/1ps
module tb_uart_pkt_rx;

    localparam int  TO_CLKS = 4096;
    localparam real BIT_NS  = 420.0;

    logic       clk80MHz = 1'b0;
    logic       rst      = 1'b1;
    logic       rxOpen   = 1'b0;
    logic       UART_RX  = 1'b1;
    logic       UART_dRX;
    logic       wrEn;
    logic [4:0] wrAddr;
    logic [7:0] wrData;
    logic       pktDone;
    logic       pktOk;
    logic       errFrame;
    logic       errTimeout;
    logic       errSeq;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_pkt_rx dut (
        .clk80MHz   (clk80MHz),
        .rst        (rst),
        .rxOpen     (rxOpen),
        .UART_RX    (UART_RX),
        .UART_dRX   (UART_dRX),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .pktDone    (pktDone),
        .pktOk      (pktOk),
        .errFrame   (errFrame),
        .errTimeout (errTimeout),
        .errSeq     (errSeq),
        .busy       (busy)
    );

    always #6.25 clk80MHz = ~clk80MHz;

    always @(posedge clk80MHz) cyc++;

    // Write/done recorder; the test tasks compare what it captured.
    int         wr_n = 0;
    int         done_n = 0;
    int         last_wr_cyc = 0;
    int         done_cyc = 0;
    int         open_cyc = 0;
    logic [4:0] wa_log [64];
    logic [7:0] wd_log [64];
    logic       d_ok, d_fr, d_to, d_sq;
    logic [7:0] pkt [20];

    always @(negedge clk80MHz) begin
        if (wrEn) begin
            if (wr_n < 64) begin
                wa_log[wr_n] = wrAddr;
                wd_log[wr_n] = wrData;
            end
            wr_n++;
            last_wr_cyc = cyc;
        end
        if (pktDone) begin
            done_n++;
            done_cyc = cyc;
            d_ok = pktOk;
            d_fr = errFrame;
            d_to = errTimeout;
            d_sq = errSeq;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        UART_RX = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            #(BIT_NS);
        end
        UART_RX = stop_bit;
        #(BIT_NS);
        UART_RX = 1'b1;
        #60;
    endtask

    task automatic fill_pkt(input logic [7:0] b0);
        pkt[0] = b0;
        for (int i = 1; i < 20; i++) pkt[i] = 8'((50 * (i + 1)) & 255);
    endtask

    task automatic open_win();
        @(negedge clk80MHz);
        rxOpen   = 1'b1;
        open_cyc = cyc;
        @(negedge clk80MHz);
        rxOpen = 1'b0;
        #100;
    endtask

    task automatic wait_done(input int n0, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk80MHz);
            if (done_n > n0) begin
                got = 1'b1;
                break;
            end
        end
        @(negedge clk80MHz);
    endtask

    task automatic rx_packet(input logic [7:0] b0, output bit got);
        int n0;
        n0   = done_n;
        wr_n = 0;
        open_win();
        fill_pkt(b0);
        for (int i = 0; i < 20; i++) send_byte(pkt[i], 1'b1);
        wait_done(n0, 500, got);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk80MHz);
        checks++;
        if ({UART_dRX, wrEn, pktDone, pktOk, errFrame, errTimeout, errSeq, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {UART_dRX, wrEn, pktDone, pktOk, errFrame, errTimeout, errSeq, busy});
        end
        checks++;
        if ({wrAddr, wrData} !== 13'h0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h/%h expected 00/00", wrAddr, wrData);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk80MHz);
    endtask

    task automatic test_basic();
        bit got;
        int n0;
        n0   = done_n;
        wr_n = 0;
        open_win();
        checks++;
        if ({UART_dRX, busy} !== 2'b11) begin
            errors++;
            $display("FAIL basic_open: got dRX/busy %b expected 11", {UART_dRX, busy});
        end
        fill_pkt(8'd0);
        for (int i = 0; i < 20; i++) send_byte(pkt[i], 1'b1);
        wait_done(n0, 500, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL basic_done: no pktDone within budget");
        end
        checks++;
        if (wr_n !== 20) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d expected 20", wr_n);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (wa_log[i] !== 5'(i) || wd_log[i] !== pkt[i]) begin
                errors++;
                $display("FAIL basic_write[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         i, wa_log[i], wd_log[i], i, pkt[i]);
            end
        end
        checks++;
        if ({d_ok, d_fr, d_to, d_sq} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_status: got ok/fr/to/sq %b expected 1000", {d_ok, d_fr, d_to, d_sq});
        end
        checks++;
        if (done_cyc !== last_wr_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d cycles expected 1", done_cyc - last_wr_cyc);
        end
        repeat (2) @(negedge clk80MHz);
        checks++;
        if ({UART_dRX, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_close: got dRX/busy %b expected 00", {UART_dRX, busy});
        end
    endtask

    task automatic test_seq();
        logic [7:0] b0s    [4] = '{8'd8, 8'd16, 8'd32, 8'd40};
        logic       exp_ok [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       exp_sq [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit got;
        for (int k = 0; k < 4; k++) begin
            rx_packet(b0s[k], got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL seq_done[%0d]: no pktDone within budget", k);
            end
            checks++;
            if ({d_ok, d_sq, d_fr, d_to} !== {exp_ok[k], exp_sq[k], 2'b00}) begin
                errors++;
                $display("FAIL seq_status[%0d]: got ok/sq/fr/to %b expected %b%b00",
                         k, {d_ok, d_sq, d_fr, d_to}, exp_ok[k], exp_sq[k]);
            end
        end
    endtask

    task automatic test_frame();
        bit got;
        int n0;
        n0   = done_n;
        wr_n = 0;
        open_win();
        fill_pkt(8'd48);
        for (int i = 0; i < 5; i++) send_byte(pkt[i], 1'b1);
        send_byte(pkt[5], 1'b0);
        wait_done(n0, 500, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL frame_done: no pktDone within budget");
        end
        checks++;
        if (wr_n !== 5) begin
            errors++;
            $display("FAIL frame_wr_count: got %0d expected 5", wr_n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wa_log[i] !== 5'(i)) begin
                errors++;
                $display("FAIL frame_addr[%0d]: got %0d expected %0d", i, wa_log[i], i);
            end
        end
        checks++;
        if ({d_ok, d_fr, d_to, d_sq} !== 4'b0100) begin
            errors++;
            $display("FAIL frame_status: got ok/fr/to/sq %b expected 0100", {d_ok, d_fr, d_to, d_sq});
        end
    endtask

    task automatic test_timeout();
        bit got;
        int n0;
        int lat;
        n0   = done_n;
        wr_n = 0;
        open_win();
        wait_done(n0, TO_CLKS + 100, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_done: no pktDone within budget");
        end
        lat = done_cyc - open_cyc;
        checks++;
        if (lat < TO_CLKS + 1 || lat > TO_CLKS + 3) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", lat, TO_CLKS + 1, TO_CLKS + 3);
        end
        checks++;
        if ({d_ok, d_fr, d_to, d_sq} !== 4'b0010 || wr_n !== 0) begin
            errors++;
            $display("FAIL timeout_status: got ok/fr/to/sq %b writes %0d expected 0010 writes 0",
                     {d_ok, d_fr, d_to, d_sq}, wr_n);
        end

        n0   = done_n;
        wr_n = 0;
        open_win();
        fill_pkt(8'd48);
        for (int i = 0; i < 7; i++) send_byte(pkt[i], 1'b1);
        wait_done(n0, TO_CLKS + 200, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout7_done: no pktDone within budget");
        end
        checks++;
        if ({d_ok, d_fr, d_to, d_sq} !== 4'b0010 || wr_n !== 7) begin
            errors++;
            $display("FAIL timeout7_status: got ok/fr/to/sq %b writes %0d expected 0010 writes 7",
                     {d_ok, d_fr, d_to, d_sq}, wr_n);
        end
    endtask

    task automatic test_glitch();
        bit got;
        int n0;
        n0   = done_n;
        wr_n = 0;
        open_win();
        UART_RX = 1'b0;
        #100;
        UART_RX = 1'b1;
        #600;
        checks++;
        if (done_n !== n0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_ignored: got done %0d busy %b expected done %0d busy 1", done_n, busy, n0);
        end
        fill_pkt(8'd48);
        for (int i = 0; i < 20; i++) send_byte(pkt[i], 1'b1);
        wait_done(n0, 500, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL glitch_done: no pktDone within budget");
        end
        checks++;
        if ({d_ok, d_fr, d_to, d_sq} !== 4'b1000 || wr_n !== 20) begin
            errors++;
            $display("FAIL glitch_status: got ok/fr/to/sq %b writes %0d expected 1000 writes 20",
                     {d_ok, d_fr, d_to, d_sq}, wr_n);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int n0;
        n0   = done_n;
        wr_n = 0;
        open_win();
        fill_pkt(8'd56);
        for (int i = 0; i < 10; i++) send_byte(pkt[i], 1'b1);
        UART_RX = 1'b0;
        #(BIT_NS * 3.5);
        @(negedge clk80MHz);
        checks++;
        if (wrAddr !== 5'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got addr %0d busy %b expected addr 9 busy 1", wrAddr, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({UART_dRX, wrEn, pktDone, pktOk, errFrame, errTimeout, errSeq, busy} !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b expected 00000000",
                     {UART_dRX, wrEn, pktDone, pktOk, errFrame, errTimeout, errSeq, busy});
        end
        checks++;
        if ({wrAddr, wrData} !== 13'h0) begin
            errors++;
            $display("FAIL rstmid_addr_data: got %h/%h expected 00/00", wrAddr, wrData);
        end
        repeat (4) @(negedge clk80MHz);
        rst     = 1'b0;
        UART_RX = 1'b1;
        #1000;
        checks++;
        if (done_n !== n0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d pktDone expected 0", done_n - n0);
        end
        rx_packet(8'd200, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rstmid_next_done: no pktDone within budget");
        end
        checks++;
        if ({d_ok, d_fr, d_to, d_sq} !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_next_status: got ok/fr/to/sq %b expected 1000", {d_ok, d_fr, d_to, d_sq});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_frame();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
